alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Execute-to-memory pipeline stage. Sits directly downstream of the arithmetic/logic unit.
//  Registers the unit's 32-bit result and Z/C/N/V flags with the destination register tag.
//  Uses a valid/ready handshake and a 2-entry skid buffer, so it sustains 1 op/cycle under backpressure.
//  Raises a precise overflow trap for signed add/sub.
//  Holds the architectural flag register and a saturating trap counter.
// PARAMETERS
//  DATA_W      32  datapath width (result, out_result)
//  REG_ADDR_W  5   destination register tag width
//  CNT_W       8   width of saturating overflow-trap counter
// PORTS
//  clk           in   1           clock, all state on rising edge
//  rst           in   1           synchronous, active-high reset
//  in_valid      in   1           upstream op valid this cycle
//  in_ready      out  1           stage can accept (registered; = ~skid_valid)
//  in_result     in   DATA_W      ALU result
//  in_zero       in   1           ALU zero flag
//  in_carry      in   1           ALU carry flag
//  in_neg        in   1           ALU negative flag
//  in_ovf        in   1           ALU overflow flag
//  in_op         in   4           ALU operation code of this op
//  in_rd         in   REG_ADDR_W  destination register
//  in_wen        in   1           op writes register file
//  in_flag_en    in   1           op updates flag register
//  flush         in   1           discard all held and incoming ops
//  out_valid     out  1           downstream entry valid
//  out_ready     in   1           downstream accepts
//  out_result    out  DATA_W      registered result
//  out_rd        out  REG_ADDR_W  registered destination
//  out_wen       out  1           qualified write enable
//  out_ovf_trap  out  1           entry carries an overflow trap
//  flags_q       out  4           architectural flags {Z,C,N,V}
//  trap_count    out  CNT_W       saturating count of retired traps
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, flags_q=0, trap_count=0.
//   All data outputs are 0 and both buffer entries are invalid.
//  Reset overrides flush and all handshakes. A reset mid-stream drops every held op.
//  Handshake:
//   - Accept when in_valid&in_ready.
//   - Retire when out_valid&out_ready.
//   - in_ready depends only on registered state, never on out_ready.
//  Entries are MAIN (drives out_*) and SKID.
//   - If MAIN is empty or retiring, MAIN loads SKID if SKID is valid, else the accepted input.
//   - If MAIN is full and not retiring and an op is accepted, the op goes to SKID.
//   - SKID is only valid while MAIN is valid.
//   - Simultaneous accept, retire and SKID valid: SKID->MAIN and input->SKID.
//  Latency: accept in cycle N gives out_valid in cycle N+1 when unstalled.
//   Order is strictly FIFO and no entry is ever duplicated or dropped, except by flush or rst.
//  Capture qualification (computed on accept):
//   - trap = in_ovf & (in_op==4'b0010 | in_op==4'b0011).
//   - wen  = in_wen & ~trap & (in_rd!=0).
//   - The result is stored unmodified even when trap=1.
//  Flag register: on retire with flag_en=1, flags_q <= {Z,C,N,V} of the retiring entry.
//   It updates in the cycle after retire, including when that entry has trap=1. Otherwise it holds.
//  trap_count: increments on retire of a trap entry and saturates at all-ones (no wrap).
//  flush:
//   - Both entries are invalidated next cycle and any same-cycle input is dropped.
//   - in_ready=1 next cycle.
//   - A same-cycle retire still completes and updates flags/counter.
//  out_* data is don't-care while out_valid=0. Implementation drives the MAIN contents.
//  Max states: EMPTY (no valid entries), ONE (MAIN valid), FULL (MAIN+SKID valid).
//   in_ready=0 only in FULL.
// TESTING
//  1. Stream ops 0..9 with in_valid=1 and out_ready=1 -> each appears 1 cycle later.
//     Throughput is 1/cycle and in_ready stays 1.
//  2. Hold out_ready=0 and send A,B,C -> in_ready=0 after B (FULL) and C stalls upstream.
//     Raise out_ready -> A,B,C retire in order with no gaps.
//  3. op=0010, result 0x80000000, in_ovf=1, in_wen=1, rd=5 -> out_wen=0 and out_ovf_trap=1.
//     Then trap_count=1 after retire. The same data with op=0000 gives no trap and out_wen=1.
//  4. Flags: retire op with Z=1, flag_en=1 -> flags_q=4'b1000.
//     Then retire op with flag_en=0 and N=1 -> flags_q stays 4'b1000.
//  5. FULL, then flush with in_valid=1 -> out_valid=0 and in_ready=1 next cycle.
//     The flushed ops never appear. The rd=0 with in_wen=1 case gives out_wen=0.
//  6. rst asserted in FULL -> next cycle all reset values hold.
//     255 trap retires plus 2 more -> trap_count=8'hFF.

Source files
------------

// File: rtl/alu_result_stage.sv
// Execute-to-memory result stage: registers ALU result, flags and destination tag
// behind a valid/ready handshake with a two-entry (MAIN + SKID) buffer.
module alu_result_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic                  in_zero,
  input  logic                  in_carry,
  input  logic                  in_neg,
  input  logic                  in_ovf,
  input  logic [3:0]            in_op,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_flag_en,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wen,
  output logic                  out_ovf_trap,
  output logic [3:0]            flags_q,
  output logic [CNT_W-1:0]      trap_count
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;

  typedef struct packed {
    logic signed [DATA_W-1:0] result;
    logic [REG_ADDR_W-1:0]    rd;
    logic                     wen;
    logic                     trap;
    logic [3:0]               flags;
    logic                     flag_en;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_nxt;
  entry_t cap_p0, main_p1, skid_p1;
  logic   cap_trap_p0;
  logic   vld_p1, skid_vld_p1;
  logic   accept, retire, load_main, load_skid;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign vld_p1      = (state != EMPTY);
  assign skid_vld_p1 = (state == FULL);
  assign in_ready    = ~skid_vld_p1;
  assign accept      = in_valid & in_ready & ~flush;
  assign retire      = vld_p1 & out_ready;

  // Stage p0: qualify the incoming op; a trapping op never writes the register file
  assign cap_trap_p0     = in_ovf & ((in_op == OP_ADD) | (in_op == OP_SUB));
  assign cap_p0.result   = in_result;
  assign cap_p0.rd       = in_rd;
  assign cap_p0.wen      = in_wen & ~cap_trap_p0 & (in_rd != '0);
  assign cap_p0.trap     = cap_trap_p0;
  assign cap_p0.flags    = {in_zero, in_carry, in_neg, in_ovf};
  assign cap_p0.flag_en  = in_flag_en;

  // MAIN refills from SKID first to keep FIFO order
  assign load_main = (~vld_p1 | retire) & (skid_vld_p1 | accept);
  assign load_skid = accept & vld_p1 & (~retire | skid_vld_p1);

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = ONE;
      ONE: begin
        if (accept & ~retire)      state_nxt = FULL;
        else if (~accept & retire) state_nxt = EMPTY;
      end
      FULL:    if (retire & ~accept) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // Stage p1: MAIN / SKID entries
  always_ff @(posedge clk) begin
    if (rst) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_main) main_p1 <= skid_vld_p1 ? skid_p1 : cap_p0;
      if (load_skid) skid_p1 <= cap_p0;
    end
  end

  // Retire side effects still complete in a flush cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q    <= '0;
      trap_count <= '0;
    end else if (retire) begin
      if (main_p1.flag_en) flags_q    <= main_p1.flags;
      if (main_p1.trap)    trap_count <= sat_inc(trap_count);
    end
  end

  assign out_valid    = vld_p1;
  assign out_result   = main_p1.result;
  assign out_rd       = main_p1.rd;
  assign out_wen      = main_p1.wen;
  assign out_ovf_trap = main_p1.trap;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage; outputs sampled on the falling edge.
module tb_alu_result_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_zero, in_carry, in_neg, in_ovf;
  logic [31:0] in_result, out_result;
  logic [3:0]  in_op, flags_q;
  logic [4:0]  in_rd, out_rd;
  logic        in_wen, in_flag_en, flush, out_valid, out_ready, out_wen, out_ovf_trap;
  logic [7:0]  trap_count;
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_carry(in_carry), .in_neg(in_neg),
    .in_ovf(in_ovf), .in_op(in_op), .in_rd(in_rd), .in_wen(in_wen),
    .in_flag_en(in_flag_en), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_wen(out_wen), .out_ovf_trap(out_ovf_trap), .flags_q(flags_q),
    .trap_count(trap_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] op,
                       input logic [3:0] zcnv, input logic [4:0] rd,
                       input logic wen, input logic fen);
    in_valid   = v;
    in_result  = res;
    in_op      = op;
    {in_zero, in_carry, in_neg, in_ovf} = zcnv;
    in_rd      = rd;
    in_wen     = wen;
    in_flag_en = fen;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    tick; tick;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_trap_count", trap_count, 0);
    chk("rst_out_result", out_result, 0);
    rst = 1'b0;

    // Streaming at one op per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + i, 4'h0, 4'h0, 5'd1, 1'b1, 1'b0);
      tick;
      chk($sformatf("stream_valid_%0d", i), out_valid, 1);
      chk($sformatf("stream_result_%0d", i), out_result, 32'h100 + i);
      chk($sformatf("stream_in_ready_%0d", i), in_ready, 1);
    end
    drive(1'b0, 32'h0, 4'h0, 4'h0, 5'd1, 1'b0, 1'b0);
    tick;
    chk("stream_drain", out_valid, 0);

    // Backpressure fills the skid entry
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 4'h0, 4'h0, 5'd2, 1'b1, 1'b0);
    tick;
    chk("bp_one_ready", in_ready, 1);
    chk("bp_one_out", out_result, 32'hA);
    drive(1'b1, 32'hB, 4'h0, 4'h0, 5'd2, 1'b1, 1'b0);
    tick;
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_out", out_result, 32'hA);
    drive(1'b1, 32'hC, 4'h0, 4'h0, 5'd2, 1'b1, 1'b0);
    tick;
    chk("bp_stall_ready", in_ready, 0);
    chk("bp_stall_out", out_result, 32'hA);
    out_ready = 1'b1;
    tick;
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_out", out_result, 32'hB);
    chk("bp_b_ready", in_ready, 1);
    tick;
    chk("bp_c_valid", out_valid, 1);
    chk("bp_c_out", out_result, 32'hC);
    drive(1'b0, 32'h0, 4'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    tick;
    chk("bp_drain", out_valid, 0);

    // Signed-add overflow trap, then the same data as a non-trapping op
    drive(1'b1, 32'h8000_0000, 4'b0010, 4'b0001, 5'd5, 1'b1, 1'b0);
    tick;
    chk("trap_wen", out_wen, 0);
    chk("trap_flag", out_ovf_trap, 1);
    chk("trap_result", out_result, 32'h8000_0000);
    chk("trap_rd", out_rd, 5);
    chk("trap_cnt_before", trap_count, 0);
    drive(1'b1, 32'h8000_0000, 4'b0000, 4'b0001, 5'd5, 1'b1, 1'b0);
    tick;
    chk("notrap_wen", out_wen, 1);
    chk("notrap_flag", out_ovf_trap, 0);
    chk("trap_cnt_after", trap_count, 1);
    drive(1'b0, 32'h0, 4'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    tick;
    chk("trap_cnt_hold", trap_count, 1);
    chk("flags_untouched", flags_q, 0);

    // Flag register updates only for flag_en entries
    drive(1'b1, 32'h0, 4'h0, 4'b1000, 5'd3, 1'b0, 1'b1);
    tick;
    chk("flags_before_retire", flags_q, 0);
    drive(1'b1, 32'h0, 4'h0, 4'b0010, 5'd3, 1'b0, 1'b0);
    tick;
    chk("flags_z", flags_q, 4'b1000);
    drive(1'b0, 32'h0, 4'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    tick;
    chk("flags_hold", flags_q, 4'b1000);

    // Flush from FULL drops held and incoming ops
    out_ready = 1'b0;
    drive(1'b1, 32'hF1, 4'h0, 4'h0, 5'd4, 1'b1, 1'b0);
    tick;
    drive(1'b1, 32'hF2, 4'h0, 4'h0, 5'd4, 1'b1, 1'b0);
    tick;
    chk("flush_pre_full", in_ready, 0);
    drive(1'b1, 32'hF3, 4'h0, 4'h0, 5'd4, 1'b1, 1'b0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    drive(1'b0, 32'h0, 4'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick;
    chk("flush_gone", out_valid, 0);
    drive(1'b1, 32'h77, 4'h0, 4'h0, 5'd0, 1'b1, 1'b0);
    tick;
    chk("rd0_valid", out_valid, 1);
    chk("rd0_wen", out_wen, 0);
    drive(1'b0, 32'h0, 4'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    tick;

    // Reset from FULL
    out_ready = 1'b0;
    drive(1'b1, 32'hD1, 4'b0011, 4'b1001, 5'd6, 1'b1, 1'b1);
    tick;
    tick;
    chk("rst_pre_full", in_ready, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_flags", flags_q, 0);
    chk("rst2_trap_count", trap_count, 0);
    chk("rst2_out_result", out_result, 0);
    tick;
    chk("rst2_stays_empty", out_valid, 0);

    // Saturating trap counter
    out_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, i, 4'b0011, 4'b0001, 5'd7, 1'b1, 1'b0);
      tick;
    end
    drive(1'b0, 32'h0, 4'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    tick;
    chk("trap_cnt_255", trap_count, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, i, 4'b0010, 4'b0001, 5'd7, 1'b1, 1'b0);
      tick;
    end
    drive(1'b0, 32'h0, 4'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    tick;
    chk("trap_cnt_sat", trap_count, 8'hFF);
    chk("trap_cnt_flags", flags_q, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
